dsp_result_collector: RTL and testbench



---
 rtl/dsp_result_collector.sv | 138 +++++++++++++
 tb/tb_dsp_result_collector.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_result_collector.sv
// Tags each DSP48A1 op, captures P/CARRYOUT LATENCY edges after issue into a FWFT FIFO (head visible the cycle after capture).
// in_ready credit-limits in-flight plus queued results to DEPTH; optional result compare under DSP_RESULT_CHECK_EN.
module dsp_result_collector #(
    parameter int LATENCY = 4,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 8
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [TAG_W-1:0] in_tag,
`ifdef DSP_RESULT_CHECK_EN
    input  logic [47:0]      in_exp,
    output logic             mismatch,
    output logic [15:0]      err_cnt,
`endif
    input  logic [47:0]      dsp_P,
    input  logic             dsp_CARRYOUT,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TAG_W-1:0] out_tag,
    output logic [47:0]      out_P,
    output logic             out_carry,
    output logic [4:0]       pending
);
    localparam int AW = $clog2(DEPTH);

    logic               accept;
    logic               capture;
    logic               pop;
    logic               fifo_full;
    logic [LATENCY-1:0] dl_vld;
    logic [TAG_W-1:0]   dl_tag [LATENCY];
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic [TAG_W-1:0]   mem_tag [DEPTH];
    logic [47:0]        mem_p [DEPTH];
    logic [DEPTH-1:0]   mem_c;

    assign in_ready  = (pending < 5'(DEPTH));
    assign accept    = in_valid && in_ready;
    assign capture   = dl_vld[LATENCY-1];
    assign out_valid = (wr_ptr != rd_ptr);
    assign pop       = out_valid && out_ready;
    assign fifo_full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign out_tag   = mem_tag[rd_ptr[AW-1:0]];
    assign out_P     = mem_p[rd_ptr[AW-1:0]];
    assign out_carry = mem_c[rd_ptr[AW-1:0]];

    // The DSP pipeline cannot stall, so the valid shadow shifts unconditionally.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            dl_vld <= '0;
        end else begin
            dl_vld[0] <= accept;
            for (int i = 1; i < LATENCY; i++) begin
                dl_vld[i] <= dl_vld[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        dl_tag[0] <= in_tag;
        for (int i = 1; i < LATENCY; i++) begin
            dl_tag[i] <= dl_tag[i-1];
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            mem_c  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_tag[i] <= '0;
                mem_p[i]   <= '0;
            end
        end else begin
            if (capture) begin
                mem_tag[wr_ptr[AW-1:0]] <= dl_tag[LATENCY-1];
                mem_p[wr_ptr[AW-1:0]]   <= dsp_P;
                mem_c[wr_ptr[AW-1:0]]   <= dsp_CARRYOUT;
                wr_ptr                  <= wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (pop) begin
                rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Capture only moves an op from in-flight to queued; pending tracks both together.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            pending <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   pending <= pending + 5'd1;
                2'b01:   pending <= pending - 5'd1;
                default: pending <= pending;
            endcase
        end
    end

`ifdef DSP_RESULT_CHECK_EN
    logic [47:0] dl_exp [LATENCY];

    always_ff @(posedge clk) begin
        dl_exp[0] <= in_exp;
        for (int i = 1; i < LATENCY; i++) begin
            dl_exp[i] <= dl_exp[i-1];
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            mismatch <= 1'b0;
            err_cnt  <= '0;
        end else if (capture && (dsp_P != dl_exp[LATENCY-1])) begin
            mismatch <= 1'b1;
            if (err_cnt != 16'hFFFF) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end
`endif

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!RST) begin
            assert (!(capture && fifo_full))
                else $error("dsp_result_collector: capture into full result FIFO");
        end
    end
`endif

endmodule

// File: tb/tb_dsp_result_collector.sv
// Directed bench for dsp_result_collector: per-cycle vector table plus hold, reset and compare sequences.
module tb_dsp_result_collector;
    localparam logic [47:0] BAD = 48'hBAD;

    logic        clk;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_tag;
    logic [47:0] dsp_P;
    logic        dsp_CARRYOUT;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_tag;
    logic [47:0] out_P;
    logic        out_carry;
    logic [4:0]  pending;
`ifdef DSP_RESULT_CHECK_EN
    logic [47:0] in_exp;
    logic        mismatch;
    logic [15:0] err_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    dsp_result_collector #(.LATENCY(4), .DEPTH(4), .TAG_W(8)) dut (
        .clk          (clk),
        .RST          (RST),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_tag       (in_tag),
`ifdef DSP_RESULT_CHECK_EN
        .in_exp       (in_exp),
        .mismatch     (mismatch),
        .err_cnt      (err_cnt),
`endif
        .dsp_P        (dsp_P),
        .dsp_CARRYOUT (dsp_CARRYOUT),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_tag      (out_tag),
        .out_P        (out_P),
        .out_carry    (out_carry),
        .pending      (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [7:0]  tag;
        logic [47:0] p;
        logic        cy;
        logic        ordy;
        logic        e_ov;
        logic [7:0]  e_tag;
        logic [47:0] e_p;
        logic        e_cy;
        logic [4:0]  e_pend;
        logic        e_ir;
    } vec_t;

    vec_t vecs[$];

    task automatic av(input logic iv, input logic [7:0] tg, input logic [47:0] p, input logic cy,
                      input logic ordy, input logic eov, input logic [7:0] etg, input logic [47:0] ep,
                      input logic ecy, input logic [4:0] epd, input logic eir);
        vec_t r;
        r.iv = iv; r.tag = tg; r.p = p; r.cy = cy; r.ordy = ordy;
        r.e_ov = eov; r.e_tag = etg; r.e_p = ep; r.e_cy = ecy; r.e_pend = epd; r.e_ir = eir;
        vecs.push_back(r);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [7:0]  hold_tags [4];
    logic [47:0] hold_ps   [4];

    initial begin
        RST = 1'b1; in_valid = 1'b0; in_tag = 8'h00; dsp_P = 48'h0; dsp_CARRYOUT = 1'b0; out_ready = 1'b0;
`ifdef DSP_RESULT_CHECK_EN
        in_exp = 48'h0;
`endif
        #12;
        chk("rst in_ready", in_ready, 1);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_tag", out_tag, 0);
        chk("rst out_P", out_P, 0);
        chk("rst out_carry", out_carry, 0);
        chk("rst pending", pending, 0);
        RST = 1'b0;

        // Single op: tag 3 issued at edge 0, result at edge 4.
        av(1, 8'h03, BAD,      0, 1, 0, 8'h00, 48'h0,   0, 1, 1);
        av(0, 8'h00, BAD,      0, 1, 0, 8'h00, 48'h0,   0, 1, 1);
        av(0, 8'h00, BAD,      0, 1, 0, 8'h00, 48'h0,   0, 1, 1);
        av(0, 8'h00, BAD,      0, 1, 0, 8'h00, 48'h0,   0, 1, 1);
        av(0, 8'h00, 48'h32,   1, 1, 1, 8'h03, 48'h32,  1, 1, 1);
        av(0, 8'h00, BAD,      0, 1, 0, 8'h00, 48'h0,   0, 0, 1);
        av(0, 8'h00, BAD,      0, 0, 0, 8'h00, 48'h0,   0, 0, 1);
        // Back-to-back fill to full, refused issues, in-order drain with mixed accept/pop.
        av(1, 8'h01, BAD,      0, 0, 0, 8'h00, 48'h0,   0, 1, 1);
        av(1, 8'h02, BAD,      0, 0, 0, 8'h00, 48'h0,   0, 2, 1);
        av(1, 8'h03, BAD,      0, 0, 0, 8'h00, 48'h0,   0, 3, 1);
        av(1, 8'h04, BAD,      0, 0, 0, 8'h00, 48'h0,   0, 4, 0);
        av(1, 8'h99, 48'h101,  1, 0, 1, 8'h01, 48'h101, 1, 4, 0);
        av(1, 8'h99, 48'h102,  0, 0, 1, 8'h01, 48'h101, 1, 4, 0);
        av(0, 8'h00, 48'h103,  1, 0, 1, 8'h01, 48'h101, 1, 4, 0);
        av(0, 8'h00, 48'h104,  0, 0, 1, 8'h01, 48'h101, 1, 4, 0);
        av(0, 8'h00, BAD,      0, 1, 1, 8'h02, 48'h102, 0, 3, 1);
        av(1, 8'h05, BAD,      0, 1, 1, 8'h03, 48'h103, 1, 3, 1);
        av(1, 8'h06, BAD,      0, 0, 1, 8'h03, 48'h103, 1, 4, 0);
        av(1, 8'h77, BAD,      0, 1, 1, 8'h04, 48'h104, 0, 3, 1);
        av(0, 8'h00, BAD,      0, 0, 1, 8'h04, 48'h104, 0, 3, 1);
        av(0, 8'h00, 48'h105,  1, 0, 1, 8'h04, 48'h104, 0, 3, 1);
        av(0, 8'h00, 48'h106,  0, 1, 1, 8'h05, 48'h105, 1, 2, 1);
        av(0, 8'h00, BAD,      0, 1, 1, 8'h06, 48'h106, 0, 1, 1);
        av(0, 8'h00, BAD,      0, 1, 0, 8'h00, 48'h0,   0, 0, 1);

        foreach (vecs[i]) begin
            in_valid = vecs[i].iv; in_tag = vecs[i].tag; dsp_P = vecs[i].p;
            dsp_CARRYOUT = vecs[i].cy; out_ready = vecs[i].ordy;
            cyc();
            chk($sformatf("vec%0d out_valid", i), out_valid, vecs[i].e_ov);
            chk($sformatf("vec%0d pending", i), pending, vecs[i].e_pend);
            chk($sformatf("vec%0d in_ready", i), in_ready, vecs[i].e_ir);
            if (vecs[i].e_ov) begin
                chk($sformatf("vec%0d out_tag", i), out_tag, vecs[i].e_tag);
                chk($sformatf("vec%0d out_P", i), out_P, vecs[i].e_p);
                chk($sformatf("vec%0d out_carry", i), out_carry, vecs[i].e_cy);
            end
        end

        // Backpressure hold: two queued results, then fill credits and keep issuing while full.
        hold_tags[0] = 8'hA0; hold_tags[1] = 8'hA1; hold_tags[2] = 8'hB2; hold_tags[3] = 8'hB3;
        hold_ps[0] = 48'h5A0; hold_ps[1] = 48'h5A1; hold_ps[2] = 48'h5B2; hold_ps[3] = 48'h5B3;
        out_ready = 1'b0; dsp_P = BAD; dsp_CARRYOUT = 1'b0;
        in_valid = 1'b1; in_tag = hold_tags[0]; cyc();
        in_tag = hold_tags[1]; cyc();
        in_valid = 1'b0; cyc();
        cyc();
        dsp_P = hold_ps[0]; cyc();
        dsp_P = hold_ps[1]; cyc();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_tag   = (i < 2) ? hold_tags[2 + i] : 8'hEE;
            dsp_P    = (i == 4) ? hold_ps[2] : (i == 5) ? hold_ps[3] : {16'h0, $urandom};
            cyc();
            chk($sformatf("hold%0d out_valid", i), out_valid, 1);
            chk($sformatf("hold%0d out_tag", i), out_tag, hold_tags[0]);
            chk($sformatf("hold%0d out_P", i), out_P, hold_ps[0]);
            chk($sformatf("hold%0d pending", i), pending, (i == 0) ? 3 : 4);
            chk($sformatf("hold%0d in_ready", i), in_ready, (i == 0) ? 1 : 0);
        end
        in_valid = 1'b0; out_ready = 1'b1; dsp_P = BAD;
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("drain%0d out_valid", j), out_valid, 1);
            chk($sformatf("drain%0d out_tag", j), out_tag, hold_tags[j]);
            chk($sformatf("drain%0d out_P", j), out_P, hold_ps[j]);
            cyc();
        end
        chk("drain out_valid", out_valid, 0);
        chk("drain pending", pending, 0);

        // Asynchronous reset with three ops in flight.
        out_ready = 1'b0; dsp_P = 48'h777;
        in_valid = 1'b1; in_tag = 8'h31; cyc();
        in_tag = 8'h32; cyc();
        in_tag = 8'h33; cyc();
        in_valid = 1'b0;
        chk("pre-rst pending", pending, 3);
        #2 RST = 1'b1;
        #1;
        chk("midrst in_ready", in_ready, 1);
        chk("midrst out_valid", out_valid, 0);
        chk("midrst out_tag", out_tag, 0);
        chk("midrst out_P", out_P, 0);
        chk("midrst out_carry", out_carry, 0);
        chk("midrst pending", pending, 0);
        #2 RST = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk($sformatf("postrst%0d out_valid", i), out_valid, 0);
            chk($sformatf("postrst%0d pending", i), pending, 0);
        end

`ifdef DSP_RESULT_CHECK_EN
        chk("chk init mismatch", mismatch, 0);
        chk("chk init err_cnt", err_cnt, 0);
        out_ready = 1'b1; dsp_P = BAD;
        in_valid = 1'b1; in_tag = 8'h41; in_exp = 48'h64; cyc();
        in_tag = 8'h42; in_exp = 48'h70; cyc();
        in_valid = 1'b0; in_exp = 48'h0; cyc();
        cyc();
        dsp_P = 48'h63; cyc();
        chk("chk bad mismatch", mismatch, 1);
        chk("chk bad err_cnt", err_cnt, 1);
        dsp_P = 48'h70; cyc();
        chk("chk good mismatch", mismatch, 1);
        chk("chk good err_cnt", err_cnt, 1);
        dsp_P = BAD; cyc();
        cyc();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
